// File: rtl/rx78_psg.sv
// rx78_psg: SN76489-compatible sound generator (3 tone + 1 noise channel) behind Z80 port 0xFF.
// Ports: clk, reset_n (async active-low), cen (chip-clock enable), wr/din (write strobe and byte),
//        ready (low while the post-write busy window runs), audio (unsigned 10-bit mix).
`timescale 1ns/1ps
module rx78_psg #(
  parameter int PRESCALE = 16,
  parameter int BUSY_CEN = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cen,
  input  logic       wr,
  input  logic [7:0] din,
  output logic       ready,
  output logic [9:0] audio
);
  localparam logic [7:0] AMP [16] = '{8'd255, 8'd203, 8'd161, 8'd128, 8'd102, 8'd81, 8'd64, 8'd51,
                                      8'd40, 8'd32, 8'd26, 8'd20, 8'd16, 8'd13, 8'd10, 8'd0};
  logic [9:0]  r_tone [3];
  logic [10:0] r_cnt [3];
  logic        r_sq [3];
  logic        w_rl [3];
  logic [3:0]  r_att [4];
  logic [2:0]  r_nctl;
  logic [2:0]  r_latch;
  logic [3:0]  r_pre;
  logic [6:0]  r_ncnt;
  logic        r_ntog;
  logic [14:0] r_lfsr;
  logic [5:0]  r_busy;
  logic [9:0]  r_audio;
  logic [2:0]  w_tgt;
  logic        w_tick;
  logic        w_nctl_wr;
  logic        w_ntog;
  logic [9:0]  w_mix;
  // latch bytes address themselves; data bytes go to the previously latched register
  assign w_tgt     = din[7] ? din[6:4] : r_latch;
  assign w_tick    = cen && (r_pre == 4'(PRESCALE - 1));
  assign w_nctl_wr = wr && (w_tgt == 3'b110);
  // rate 3 slaves the noise toggle to tone2 reloads
  assign w_ntog    = w_tick && ((r_nctl[1:0] == 2'd3) ? w_rl[2] : (r_ncnt <= 7'd1));
  genvar g;
  for (g = 0; g < 3; g++) begin : g_tone
    assign w_rl[g] = r_cnt[g] <= 11'd1;
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        r_tone[g] <= '0;
        r_cnt[g]  <= '0;
        r_sq[g]   <= 1'b0;
      end else begin
        if (wr && w_tgt == 3'(2 * g)) begin
          if (din[7]) r_tone[g][3:0] <= din[3:0];
          else        r_tone[g][9:4] <= din[5:0];
        end
        if (w_tick) begin
          // period 0 reloads as 1024 via the extra counter bit
          r_cnt[g] <= w_rl[g] ? {r_tone[g] == 10'd0, r_tone[g]} : r_cnt[g] - 11'd1;
          if (w_rl[g]) r_sq[g] <= ~r_sq[g];
        end
      end
  end
  for (g = 0; g < 4; g++) begin : g_att
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n)                          r_att[g] <= 4'hf;
      else if (wr && w_tgt == 3'(2 * g + 1)) r_att[g] <= din[3:0];
  end
  always_comb
    w_mix = 10'(r_sq[0] ? AMP[r_att[0]] : 8'd0) + 10'(r_sq[1] ? AMP[r_att[1]] : 8'd0)
          + 10'(r_sq[2] ? AMP[r_att[2]] : 8'd0) + 10'(r_lfsr[0] ? AMP[r_att[3]] : 8'd0);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_latch <= '0;
      r_nctl  <= '0;
      r_pre   <= '0;
      r_ncnt  <= '0;
      r_ntog  <= 1'b0;
      r_lfsr  <= 15'h4000;
      r_busy  <= '0;
      r_audio <= '0;
    end else begin
      if (wr && din[7]) r_latch <= din[6:4];
      if (w_nctl_wr) r_nctl <= din[2:0];
      if (cen) r_pre <= w_tick ? 4'd0 : r_pre + 4'd1;
      if (w_tick) r_ncnt <= (r_ncnt > 7'd1) ? r_ncnt - 7'd1 : 7'd16 << r_nctl[1:0];
      // an nctl write wins over a shift landing on the same edge
      if (w_nctl_wr) begin
        r_lfsr <= 15'h4000;
        r_ntog <= 1'b0;
      end else if (w_ntog) begin
        r_ntog <= ~r_ntog;
        if (!r_ntog) r_lfsr <= {r_nctl[2] ? ^r_lfsr[1:0] : r_lfsr[0], r_lfsr[14:1]};
      end
      r_busy  <= wr ? 6'(BUSY_CEN) : ((cen && r_busy != 6'd0) ? r_busy - 6'd1 : r_busy);
      r_audio <= w_mix;
    end
  assign ready = r_busy == 6'd0;
  assign audio = r_audio;
endmodule

// File: tb/tb_rx78_psg.sv
// tb_rx78_psg: randomized self-checking bench for rx78_psg against a closed-form tick model.
`timescale 1ns/1ps
module tb_rx78_psg;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cen = 1'b0;
  logic       wr = 1'b0;
  logic [7:0] din = 8'h00;
  logic       ready;
  logic [9:0] audio;
  int total = 0;
  int bad = 0;
  int n_cen = 0;

  always #5 clk = ~clk;

  rx78_psg dut (.clk(clk), .reset_n(reset_n), .cen(cen), .wr(wr), .din(din), .ready(ready), .audio(audio));

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // number of toggles after t ticks for a channel first toggling at tick start, then every r ticks
  function automatic int toggles(int t, int start, int r);
    return (t >= start) ? (t - start) / r + 1 : 0;
  endfunction

  // noise output after s shifts from the reset seed
  function automatic bit nbit(int s, bit white);
    logic [14:0] l;
    l = 15'h4000;
    for (int i = 0; i < s; i++) l = {white ? (l[0] ^ l[1]) : l[0], l[14:1]};
    return l[0];
  endfunction

  task automatic clk_cycle(input bit c, input bit w, input logic [7:0] d);
    cen = c;
    wr  = w;
    din = d;
    @(posedge clk);
    #1;
    if (c) n_cen++;
    cen = 1'b0;
    wr  = 1'b0;
  endtask

  task automatic write(input logic [7:0] d);
    clk_cycle(1'b0, 1'b1, d);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    n_cen = 0;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    total++;
    if (audio !== 10'd0) begin bad++; $display("FAIL reset_audio got=%0d want=0", audio); end
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready); end
    reset_n = 1'b1;
    n_cen = 0;
    repeat (60) begin
      clk_cycle($urandom_range(0, 1) == 1, 1'b0, 8'h00);
      total++;
      if (audio !== 10'd0) begin bad++; $display("FAIL reset_silent got=%0d want=0", audio); end
    end
  endtask

  task automatic test_tone();
    int nb, e;
    apply_reset();
    write(8'h80);
    write(8'h01);
    write(8'h90);
    repeat (1200) begin
      nb = n_cen;
      clk_cycle($urandom_range(0, 3) != 0, 1'b0, 8'h00);
      e = (toggles(nb / 16, 1, 16) % 2 == 1) ? 255 : 0;
      total++;
      if (audio !== 10'(e)) begin bad++; $display("FAIL tone cen=%0d got=%0d want=%0d", nb, audio, e); end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 600; i++) begin
      if (toggles(n_cen / 16, 1, 16) % 2 == 1) break;
      clk_cycle(1'b1, 1'b0, 8'h00);
    end
    write(8'h91);
    total++;
    if (audio !== 10'd255) begin bad++; $display("FAIL att_latency_old got=%0d want=255", audio); end
    clk_cycle(1'b0, 1'b0, 8'h00);
    total++;
    if (audio !== 10'd203) begin bad++; $display("FAIL att_latency_new got=%0d want=203", audio); end
    write(8'h90);
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (audio !== 10'd0) begin bad++; $display("FAIL midreset_audio got=%0d want=0", audio); end
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL midreset_ready got=%b want=1", ready); end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    n_cen = 0;
    repeat (300) begin
      clk_cycle($urandom_range(0, 3) != 0, 1'b0, 8'h00);
      total++;
      if (audio !== 10'd0) begin bad++; $display("FAIL midreset_silent got=%0d want=0", audio); end
    end
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL midreset_ready_after got=%b want=1", ready); end
  endtask

  task automatic test_mix();
    int nb, t, e, s0;
    apply_reset();
    write(8'h80);
    write(8'h01);
    write(8'h90);
    write(8'hB5);
    write(8'hA1);
    write(8'h00);
    repeat (800) begin
      nb = n_cen;
      clk_cycle($urandom_range(0, 3) != 0, 1'b0, 8'h00);
      t = nb / 16;
      e = 255 * (toggles(t, 1, 16) % 2) + 81 * (toggles(t, 1, 1) % 2);
      total++;
      if (audio !== 10'(e)) begin bad++; $display("FAIL mix cen=%0d got=%0d want=%0d", nb, audio, e); end
    end
    for (int i = 0; i < 64; i++) begin
      if (toggles(n_cen / 16, 1, 1) % 2 == 1) break;
      clk_cycle(1'b1, 1'b0, 8'h00);
    end
    s0 = toggles(n_cen / 16, 1, 16) % 2;
    write(8'hB0);
    e = 255 * s0 + 81;
    total++;
    if (audio !== 10'(e)) begin bad++; $display("FAIL mix_att_old got=%0d want=%0d", audio, e); end
    clk_cycle(1'b0, 1'b0, 8'h00);
    e = 255 * s0 + 255;
    total++;
    if (audio !== 10'(e)) begin bad++; $display("FAIL mix_att_new got=%0d want=%0d", audio, e); end
  endtask

  task automatic test_busy();
    int k, e;
    bit c;
    apply_reset();
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL busy_idle got=%b want=1", ready); end
    write(8'hD0);
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL busy_fall got=%b want=0", ready); end
    k = 0;
    for (int i = 0; i < 200 && k < 10; i++) begin
      c = $urandom_range(0, 1) == 1;
      clk_cycle(c, 1'b0, 8'h00);
      if (c) k++;
      total++;
      if (ready !== 1'b0) begin bad++; $display("FAIL busy_first k=%0d got=%b want=0", k, ready); end
    end
    write(8'hB0);
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL busy_retrigger got=%b want=0", ready); end
    k = 0;
    for (int i = 0; i < 400 && k < 36; i++) begin
      c = $urandom_range(0, 2) != 0;
      clk_cycle(c, 1'b0, 8'h00);
      if (c) k++;
      total++;
      if (ready !== (k >= 32)) begin bad++; $display("FAIL busy_window k=%0d got=%b want=%b", k, ready, k >= 32); end
    end
    total++;
    if (k < 36) begin bad++; $display("FAIL busy_bound cen_seen=%0d want=36", k); end
    clk_cycle(1'b0, 1'b0, 8'h00);
    e = 510 * (toggles(n_cen / 16, 1, 1024) % 2);
    total++;
    if (audio !== 10'(e)) begin bad++; $display("FAIL busy_both_writes got=%0d want=%0d", audio, e); end
  endtask

  task automatic test_same_cycle_tone();
    int nb, t, e;
    apply_reset();
    write(8'h90);
    write(8'h80);
    write(8'h02);
    repeat (15) clk_cycle(1'b1, 1'b0, 8'h00);
    clk_cycle(1'b1, 1'b1, 8'h00);
    repeat (1500) begin
      nb = n_cen;
      clk_cycle($urandom_range(0, 3) != 0, 1'b0, 8'h00);
      t = nb / 16;
      e = (((t >= 1) + (t >= 33) + (t >= 1057)) % 2 == 1) ? 255 : 0;
      total++;
      if (audio !== 10'(e)) begin bad++; $display("FAIL same_tone cen=%0d got=%0d want=%0d", nb, audio, e); end
    end
  endtask

  task automatic test_noise(input bit white, input logic [7:0] ctl);
    int nb, s, e;
    apply_reset();
    write(ctl);
    write(8'hF0);
    repeat (16416) begin
      nb = n_cen;
      clk_cycle(1'b1, 1'b0, 8'h00);
      s = (toggles(nb / 16, 1, 16) + 1) / 2;
      e = nbit(s, white) ? 255 : 0;
      total++;
      if (audio !== 10'(e)) begin bad++; $display("FAIL noise white=%0d shifts=%0d got=%0d want=%0d", white, s, audio, e); end
    end
  endtask

  task automatic test_same_cycle_noise();
    int nb, s, e;
    apply_reset();
    write(8'hF0);
    repeat (15) clk_cycle(1'b1, 1'b0, 8'h00);
    clk_cycle(1'b1, 1'b1, 8'hE4);
    repeat (8000) begin
      nb = n_cen;
      clk_cycle(1'b1, 1'b0, 8'h00);
      s = (toggles(nb / 16, 17, 16) + 1) / 2;
      e = nbit(s, 1'b1) ? 255 : 0;
      total++;
      if (audio !== 10'(e)) begin bad++; $display("FAIL same_noise shifts=%0d got=%0d want=%0d", s, audio, e); end
    end
  endtask

  initial begin
    test_reset();
    test_tone();
    test_reset_mid();
    test_mix();
    test_busy();
    test_same_cycle_tone();
    test_noise(1'b1, 8'hE4);
    test_noise(1'b0, 8'hE0);
    test_same_cycle_noise();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
